// File: rtl/word_assembler_if.sv
// Byte-in / word-out handshake bundle for word_assembler.
// Optional feature macro: WORD_ASSEMBLER_FLUSH_EN adds flush and out_bytes.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both 1. Valid, once raised by a producer,
// holds its payload stable until the transfer happens. Ready may depend
// combinationally on the other side's signals; valid never depends on ready.
interface word_assembler_if;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic [1:0]  byte_cnt;
`ifdef WORD_ASSEMBLER_FLUSH_EN
   logic        flush;
   logic [2:0]  out_bytes;

   // Byte producer / word consumer side.
   modport master (
      output in_valid, in_byte, out_ready, flush,
      input  in_ready, out_valid, out_data, byte_cnt, out_bytes
   );

   // Assembler side.
   modport slave (
      input  in_valid, in_byte, out_ready, flush,
      output in_ready, out_valid, out_data, byte_cnt, out_bytes
   );
`else
   // Byte producer / word consumer side.
   modport master (
      output in_valid, in_byte, out_ready,
      input  in_ready, out_valid, out_data, byte_cnt
   );

   // Assembler side.
   modport slave (
      input  in_valid, in_byte, out_ready,
      output in_ready, out_valid, out_data, byte_cnt
   );
`endif
endinterface

// File: rtl/word_assembler.sv
// Packs a stream of bytes into 32-bit words, first byte in [31:24].
// A one-word output register lets bytes 1-3 of the next word arrive while
// the previous word waits for the consumer; only the 4th byte can stall.
// Optional feature macro: WORD_ASSEMBLER_FLUSH_EN emits a left-aligned,
// zero-padded partial word on flush and reports its byte count on out_bytes.
module word_assembler (
   input  logic            clk,
   input  logic            reset,
   word_assembler_if.slave bus
);

   logic [23:0] acc_q, acc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;

   logic in_ready;
   logic in_acc;
   logic out_xfer;
   logic word_done;

   // The output register is free for a new word unless it holds one that
   // the consumer is not taking this cycle; only the 4th byte needs that.
   assign in_ready  = (cnt_q != 2'd3) | ~out_valid_q | bus.out_ready;
   assign in_acc    = bus.in_valid & in_ready;
   assign out_xfer  = out_valid_q & bus.out_ready;
   assign word_done = in_acc & (cnt_q == 2'd3);

`ifdef WORD_ASSEMBLER_FLUSH_EN
   logic [2:0] out_bytes_q, out_bytes_d;
   logic [1:0] fill_cnt;
   logic       flush_emit;

   // Byte count including any byte accepted this same cycle; a completing
   // word is handled as a normal emit, so flush only acts on partials.
   assign fill_cnt   = in_acc ? (cnt_q + 2'd1) : cnt_q;
   assign flush_emit = bus.flush & (~out_valid_q | bus.out_ready) &
                       ~word_done & (fill_cnt != 2'd0);
`endif

   // Next-state: accumulate bytes, load and drain the output register.
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
`ifdef WORD_ASSEMBLER_FLUSH_EN
      out_bytes_d = out_bytes_q;
`endif
      if (out_xfer) begin
         out_valid_d = 1'b0;
      end
      if (in_acc) begin
         cnt_d = cnt_q + 2'd1;
         // Starting a word clears the low bytes so a partial is zero-padded.
         case (cnt_q)
            2'd0:    acc_d = {bus.in_byte, 16'h0000};
            2'd1:    acc_d[15:8] = bus.in_byte;
            2'd2:    acc_d[7:0]  = bus.in_byte;
            default: acc_d = 24'h00_0000;
         endcase
      end
      if (word_done) begin
         out_data_d  = {acc_q, bus.in_byte};
         out_valid_d = 1'b1;
      end
`ifdef WORD_ASSEMBLER_FLUSH_EN
      if (word_done) begin
         out_bytes_d = 3'd4;
      end else if (flush_emit) begin
         out_data_d  = {acc_d, 8'h00};
         out_valid_d = 1'b1;
         out_bytes_d = {1'b0, fill_cnt};
         cnt_d       = 2'd0;
         acc_d       = 24'h00_0000;
      end
`endif
   end

   // State registers; reset discards any partial or pending word.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= 24'h00_0000;
         cnt_q       <= 2'd0;
         out_data_q  <= 32'h0000_0000;
         out_valid_q <= 1'b0;
`ifdef WORD_ASSEMBLER_FLUSH_EN
         out_bytes_q <= 3'd0;
`endif
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
`ifdef WORD_ASSEMBLER_FLUSH_EN
         out_bytes_q <= out_bytes_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.byte_cnt  = cnt_q;
`ifdef WORD_ASSEMBLER_FLUSH_EN
   assign bus.out_bytes = out_bytes_q;
`endif

endmodule
